// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider.
// Holds the FSM state encoding and a helper that sizes the iteration counter.
// Imported by seq_divider; carries no logic of its own.
package seq_divider_pkg;

  // FSM encoding; values are fixed so waveforms and debug dumps stay comparable.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Iteration counter width: it must hold W-1, so $clog2(W) bits.
  // The result is never allowed to drop below 1 bit.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/seq_divider_addsub_n.sv
// Purpose: N-bit ripple adder-subtractor; ctrl=0 gives a+b, ctrl=1 gives a-b.
// Latency: purely combinational, no clock.
// Backpressure: none; the outputs follow the inputs.
// Ports:
//   a, b  : N-bit operands
//   ctrl  : inverts b and is used as the carry-in (0 = add, 1 = subtract)
//   s     : N-bit sum or difference
//   cout  : carry out; on subtract, 1 means no borrow (a >= b)
module addsub_n #(
  parameter int N = 5
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ctrl,
  output logic [N-1:0] s,
  output logic         cout
);

  logic [N-1:0] w_b_eff;
  logic [N:0]   w_carry;

  assign w_b_eff = b ^ {N{ctrl}};

  // Explicit carry chain, one full adder per bit.
  always_comb begin
    w_carry    = '0;
    s          = '0;
    w_carry[0] = ctrl;
    for (int i = 0; i < N; i++) begin
      s[i]         = a[i] ^ w_b_eff[i] ^ w_carry[i];
      w_carry[i+1] = (a[i] & w_b_eff[i]) | (w_carry[i] & (a[i] ^ w_b_eff[i]));
    end
  end

  assign cout = w_carry[N];

endmodule

// File: rtl/seq_divider.sv
// Purpose: multi-cycle unsigned restoring divider, one quotient bit per clock.
// Latency: out_valid rises W cycles after the accept edge; one op per W+2 cycles.
// Backpressure: out_ready low holds the result in DONE; in_ready stays low until the
//   result is taken.
// Ports:
//   clk, rst_n           : clock and asynchronous active-low reset
//   in_valid / in_ready  : operand handshake; dividend and divisor are sampled on accept
//   dividend, divisor    : W-bit unsigned operands
//   out_valid / out_ready: result handshake
//   quotient, remainder  : W-bit unsigned results
//   div_by_zero          : result came from a zero divisor (quotient all ones, rem = dividend)
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = cnt_width(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  state_t        r_state;
  state_t        w_state_nxt;

  logic [W-1:0]  r_q;      // dividend shifts out the top, quotient bits shift in the bottom
  logic [W-1:0]  r_r;      // partial remainder
  logic [W-1:0]  r_d;      // latched divisor
  logic [CW-1:0] r_cnt;
  logic          r_dbz;

  logic          w_accept;
  logic          w_xfer;
  logic          w_last;
  logic [W:0]    w_trial;
  logic [W:0]    w_diff;
  logic          w_cout;
  logic [W-1:0]  w_r_nxt;

  // -------------------------------------------------------------------------
  // Datapath: trial subtraction on the shared add/sub block
  // -------------------------------------------------------------------------
  assign w_trial = {r_r, r_q[W-1]};

  addsub_n #(
    .N (W + 1)
  ) u_addsub (
    .a    (w_trial),
    .b    ({1'b0, r_d}),
    .ctrl (1'b1),
    .s    (w_diff),
    .cout (w_cout)
  );

  // No borrow: keep the difference. Borrow: restore the trial value.
  // R < D always holds, so the trial value is below 2*D and neither candidate needs bit W.
  assign w_r_nxt = w_cout ? w_diff[W-1:0] : w_trial[W-1:0];

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (in_valid) w_state_nxt = ST_BUSY;
      ST_BUSY: if (w_last)   w_state_nxt = ST_DONE;
      ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs and handshake strobes
  // -------------------------------------------------------------------------
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (r_state)
      ST_IDLE: in_ready  = 1'b1;
      ST_BUSY: ;
      ST_DONE: out_valid = 1'b1;
      default: ;
    endcase
  end

  assign w_accept = in_valid & in_ready;
  assign w_xfer   = out_valid & out_ready;
  assign w_last   = (r_cnt == '0);

  // -------------------------------------------------------------------------
  // Operand / iteration registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q   <= '0;
      r_r   <= '0;
      r_d   <= '0;
      r_cnt <= '0;
      r_dbz <= 1'b0;
    end else if (w_accept) begin
      r_q   <= dividend;
      r_r   <= '0;
      r_d   <= divisor;
      r_cnt <= CNT_LAST;
      r_dbz <= (divisor == '0);
    end else if (r_state == ST_BUSY) begin
      r_q   <= {r_q[W-2:0], w_cout};
      r_r   <= w_r_nxt;
      // The counter parks at zero on the last step; the next accept reloads it.
      if (!w_last) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign quotient    = r_q;
  assign remainder   = r_r;
  assign div_by_zero = r_dbz;

  // The subtractor is one bit wider than the operands, so a successful
  // subtraction can never leave anything in the top bit.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    (r_state == ST_BUSY && w_cout) |-> !w_diff[W]);

  // The transfer strobe only matters in DONE; it is kept for the assertion below.
  a_xfer_to_idle: assert property (@(posedge clk) disable iff (!rst_n)
    w_xfer |=> (r_state == ST_IDLE));

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_checks;
  int n_fail;
  int cyc;
  int t_acc;

  seq_divider #(.W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for in_ready, then present operands for one accept edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", in_ready, 1);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    t_acc    = cyc;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      step();
      n++;
    end
    chk({tag, "_latency"}, cyc - t_acc, W);
  endtask

  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez);
    start_op(a, b);
    wait_done(tag);
    chk({tag, "_quot"}, quotient, eq);
    chk({tag, "_rem"}, remainder, er);
    chk({tag, "_dbz"}, div_by_zero, ez);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_ovld_drop"}, out_valid, 0);
    chk({tag, "_irdy_back"}, in_ready, 1);
  endtask

  initial begin
    int prev_acc;
    logic [W-1:0] eq;
    logic [W-1:0] er;
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    #23;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_quot", quotient, 0);
    chk("rst_rem", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    rst_n = 1'b1;
    step();

    // Directed vectors
    do_op("d13_3", 4'd13, 4'd3, 4'd4, 4'd1, 1'b0);
    do_op("d15_1", 4'd15, 4'd1, 4'd15, 4'd0, 1'b0);
    do_op("d2_9", 4'd2, 4'd9, 4'd0, 4'd2, 1'b0);
    do_op("d0_5", 4'd0, 4'd5, 4'd0, 4'd0, 1'b0);
    do_op("d7_0", 4'd7, 4'd0, 4'd15, 4'd7, 1'b1);
    do_op("d8_2", 4'd8, 4'd2, 4'd4, 4'd0, 1'b0);

    // Back-pressure: result held for 5 cycles, new request ignored meanwhile
    start_op(4'd13, 4'd3);
    wait_done("bp");
    in_valid = 1'b1;
    dividend = 4'd5;
    divisor  = 4'd2;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_out_valid", out_valid, 1);
      chk("bp_quot", quotient, 4);
      chk("bp_rem", remainder, 1);
      chk("bp_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_ovld_drop", out_valid, 0);
    chk("bp_irdy_back", in_ready, 1);

    // Reset mid-BUSY discards the operation
    start_op(4'd9, 4'd4);
    step();
    rst_n = 1'b0;
    #1;
    chk("mrst_in_ready", in_ready, 1);
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_quot", quotient, 0);
    chk("mrst_rem", remainder, 0);
    chk("mrst_dbz", div_by_zero, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    do_op("d9_4", 4'd9, 4'd4, 4'd2, 4'd1, 1'b0);

    // Exhaustive sweep, back-to-back requests, consumer always ready
    out_ready = 1'b1;
    in_valid  = 1'b1;
    prev_acc  = -1;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        dividend = W'(a);
        divisor  = W'(b);
        step();
        t_acc = cyc;
        if (prev_acc >= 0) chk("sw_period", t_acc - prev_acc, W + 2);
        prev_acc = t_acc;
        eq = (b == 0) ? 4'hF : W'(a / b);
        er = (b == 0) ? W'(a) : W'(a % b);
        wait_done("sw");
        chk("sw_quot", quotient, eq);
        chk("sw_rem", remainder, er);
        chk("sw_dbz", div_by_zero, (b == 0) ? 1 : 0);
        step();
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
